// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data memory.
// Port 0 is the CPU load/store stage. Port 1 is a secondary master (loader/debug/DMA).
// Optional feature macro: DATA_MEM_ARB_BOUNDS_EN adds err0/err1 and out-of-range address
// rejection (address >= MEM_DEPTH completes with ack+err and no memory strobe).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request; strobes low, mem_* hold last access
// ACCESS | strobes held for ACCESS_CYCLES cycles, counting down cnt
// RESP   | one-cycle ack (and err, when enabled) to the granted port
module data_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 2,
  parameter int MEM_DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [5:0]        opcode0,
  input  logic [ADDR_W-1:0] endereco0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [5:0]        opcode1,
  input  logic [ADDR_W-1:0] endereco1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [5:0]        mem_opcode,
  output logic              sinal_mem_write,
  output logic              sinal_mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
`ifdef DATA_MEM_ARB_BOUNDS_EN
  output logic              err0,
  output logic              err1,
`endif
  output logic              busy
);

  // Counter is 4 bits, which bounds ACCESS_CYCLES to 1..15.
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("ACCESS_CYCLES must be in 1..15");
  end
  if (MEM_DEPTH < 1) begin : g_bad_mem_depth
    $error("MEM_DEPTH must be at least 1");
  end

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                winner_q, winner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [5:0]          op_q, op_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                pick1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
`ifdef DATA_MEM_ARB_BOUNDS_EN
  localparam logic [ADDR_W-1:0] MEM_DEPTH_A = ADDR_W'(MEM_DEPTH);
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;
`endif

  // Next-state and datapath decode; every register holds unless a state updates it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef DATA_MEM_ARB_BOUNDS_EN
    err0_d       = 1'b0;
    err1_d       = 1'b0;
`endif
    // Port 1 wins when it is alone, or when both ask and port 0 had the last grant.
    pick1    = req1 & (~req0 | ~last_grant_q);
    sel_we   = pick1 ? we1 : we0;
    sel_addr = pick1 ? endereco1 : endereco0;

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          winner_d     = pick1;
          last_grant_d = pick1;
          addr_d       = sel_addr;
          wdata_d      = pick1 ? wdata1 : wdata0;
          op_d         = pick1 ? opcode1 : opcode0;
          cnt_d        = CNT_INIT;
`ifdef DATA_MEM_ARB_BOUNDS_EN
          if (sel_addr >= MEM_DEPTH_A) begin
            // Out-of-range: skip the memory entirely and answer with an error.
            state_d = S_RESP;
            if (pick1) begin
              ack1_d   = 1'b1;
              err1_d   = 1'b1;
              rdata1_d = '0;
            end else begin
              ack0_d   = 1'b1;
              err0_d   = 1'b1;
              rdata0_d = '0;
            end
          end else begin
            wr_d    = sel_we;
            rd_d    = ~sel_we;
            state_d = S_ACCESS;
          end
`else
          wr_d    = sel_we;
          rd_d    = ~sel_we;
          state_d = S_ACCESS;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = S_RESP;
          if (winner_q) begin
            ack1_d = 1'b1;
            if (rd_q) rdata1_d = mem_read_data;
          end else begin
            ack0_d = 1'b1;
            if (rd_q) rdata0_d = mem_read_data;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any access in flight without acknowledging it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef DATA_MEM_ARB_BOUNDS_EN
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef DATA_MEM_ARB_BOUNDS_EN
      err0_q       <= err0_d;
      err1_q       <= err1_d;
`endif
    end
  end

  assign mem_endereco    = addr_q;
  assign mem_write_data  = wdata_q;
  assign mem_opcode      = op_q;
  assign sinal_mem_write = wr_q;
  assign sinal_mem_read  = rd_q;
  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign rdata0          = rdata0_q;
  assign rdata1          = rdata1_q;
  assign busy            = (state_q != S_IDLE);
`ifdef DATA_MEM_ARB_BOUNDS_EN
  assign err0            = err0_q;
  assign err1            = err1_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter (default ACCESS_CYCLES=2, MEM_DEPTH=256).
module tb_data_mem_arbiter;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [5:0]  opcode0, opcode1;
  logic [31:0] endereco0, endereco1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_endereco, mem_write_data, mem_read_data;
  logic [5:0]  mem_opcode;
  logic        sinal_mem_write, sinal_mem_read, busy;
`ifdef DATA_MEM_ARB_BOUNDS_EN
  logic        err0, err1;
`endif

  logic [31:0] mem [0:255];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_endereco[7:0]];

  data_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(AC), .MEM_DEPTH(256)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .opcode0(opcode0), .endereco0(endereco0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .opcode1(opcode1), .endereco1(endereco1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_endereco(mem_endereco), .mem_write_data(mem_write_data), .mem_opcode(mem_opcode),
    .sinal_mem_write(sinal_mem_write), .sinal_mem_read(sinal_mem_read),
    .mem_read_data(mem_read_data),
`ifdef DATA_MEM_ARB_BOUNDS_EN
    .err0(err0), .err1(err1),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0 = r; we0 = we; opcode0 = op; endereco0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; opcode1 = op; endereco1 = a; wdata1 = d;
    end
  endtask

  // Called just after a rising edge with the DUT idle and the other port quiet.
  task automatic run_txn(input int p, input logic we, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    drive(p, 1'b1, we, op, a, d);
    @(posedge clk);
    for (int k = 0; k < AC; k++) begin
      @(negedge clk);
      chk("txn_wr", sinal_mem_write, we);
      chk("txn_rd", sinal_mem_read, !we);
      chk("txn_addr", mem_endereco, a);
      chk("txn_op", mem_opcode, op);
      if (we) chk("txn_wdata", mem_write_data, d);
      chk("txn_ack_early", (p == 0) ? ack0 : ack1, 1'b0);
    end
    @(negedge clk);
    chk("txn_ack", (p == 0) ? ack0 : ack1, 1'b1);
    chk("txn_ack_other", (p == 0) ? ack1 : ack0, 1'b0);
    chk("txn_strobes_off", {sinal_mem_write, sinal_mem_read}, 2'b00);
    chk("txn_rdata", (p == 0) ? rdata0 : rdata1, exp_rd);
`ifdef DATA_MEM_ARB_BOUNDS_EN
    chk("txn_no_err", {err0, err1}, 2'b00);
`endif
    drive(p, 1'b0, we, op, a, d);
    @(negedge clk);
    chk("txn_ack_one_cycle", {ack0, ack1}, 2'b00);
    chk("txn_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5]  = 32'hDEADBEEF;
    mem[7]  = 32'h0707_0707;
    mem[10] = 32'h1010_1010;
    mem[11] = 32'h1111_1111;
    mem[20] = 32'h2020_2020;
    mem[21] = 32'h2121_2121;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {sinal_mem_write, sinal_mem_read}, 2'b00);
    chk("rst_ack", {ack0, ack1}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_endereco, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_op", mem_opcode, 6'h00);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single word read from port 0, then a byte store from port 1.
    run_txn(0, 1'b0, 6'h23, 32'd5, 32'h0, 32'hDEADBEEF);
    run_txn(1, 1'b1, 6'h28, 32'd3, 32'h0000_00AB, 32'h0);
    chk("wr_keeps_rdata0", rdata0, 32'hDEADBEEF);

    // Both ports held high: grants must alternate 0,1,0,1.
    drive(0, 1'b1, 1'b0, 6'h23, 32'd10, 32'h0);
    drive(1, 1'b1, 1'b0, 6'h23, 32'd11, 32'h0);
    @(posedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("alt_no_dual_strobe", {31'b0, sinal_mem_write & sinal_mem_read}, 32'h0);
      chk("alt_busy", busy, (i % 4) != 0);
      chk("alt_ack0", ack0, ((i % 4) == 3) && (((i / 4) % 2) == 0));
      chk("alt_ack1", ack1, ((i % 4) == 3) && (((i / 4) % 2) == 1));
      if ((i % 4) == 1) chk("alt_addr", mem_endereco, (((i / 4) % 2) == 0) ? 32'd10 : 32'd11);
      if ((i % 4) == 3) begin
        if (((i / 4) % 2) == 0) chk("alt_rdata0", rdata0, 32'h1010_1010);
        else                    chk("alt_rdata1", rdata1, 32'h1111_1111);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Address changes during ACCESS must not reach the memory.
    drive(0, 1'b1, 1'b0, 6'h23, 32'd7, 32'h0);
    @(posedge clk); #1;
    endereco0 = 32'd99;
    for (int k = 0; k <= AC; k++) begin
      @(negedge clk);
      chk("hold_addr", mem_endereco, 32'd7);
    end
    chk("hold_ack0", ack0, 1'b1);
    chk("hold_rdata0", rdata0, 32'h0707_0707);
    req0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset in the middle of a port 0 write: no ack, and port 0 wins next.
    drive(0, 1'b1, 1'b1, 6'h2B, 32'd9, 32'h0000_0005);
    @(posedge clk);
    @(negedge clk);
    chk("mid_wr_active", sinal_mem_write, 1'b1);
    reset = 1'b1;
    req0  = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", {sinal_mem_write, sinal_mem_read}, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ack0", ack0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_rst_no_ack0", ack0, 1'b0);
    end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 6'h23, 32'd20, 32'h0);
    drive(1, 1'b1, 1'b0, 6'h23, 32'd21, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_grant_addr", mem_endereco, 32'd20);
    chk("post_rst_grant_rd", sinal_mem_read, 1'b1);
    repeat (AC) @(negedge clk);
    chk("post_rst_ack0", ack0, 1'b1);
    chk("post_rst_ack1", ack1, 1'b0);
    chk("post_rst_rdata0", rdata0, 32'h2020_2020);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

`ifdef DATA_MEM_ARB_BOUNDS_EN
    // Out-of-range read: ack with err the cycle after the grant, no strobe, rdata cleared.
    drive(0, 1'b1, 1'b0, 6'h23, 32'd300, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("oob_strobes", {sinal_mem_write, sinal_mem_read}, 2'b00);
    chk("oob_ack0", ack0, 1'b1);
    chk("oob_err0", err0, 1'b1);
    chk("oob_err1", err1, 1'b0);
    chk("oob_rdata0", rdata0, 32'h0);
    req0 = 1'b0;
    @(negedge clk);
    chk("oob_ack_clear", ack0, 1'b0);
    chk("oob_err_clear", err0, 1'b0);
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-port data memory.
- Port 0 is the CPU load/store stage. Port 1 is a secondary master (loader/debug/DMA).
- Grants one request at a time using round-robin priority.
- Drives the memory address, data, opcode and read/write strobes for a fixed number of cycles, captures read data, then returns a one-cycle acknowledge to the granted requester.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, data width.
- ACCESS_CYCLES, 2, cycles memory strobes are held per access (legal range 1..15).
- MEM_DEPTH, 256, number of valid memory words (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held until ack0.
- we0  in  1  port 0 write (1) / read (0).
- opcode0  in  6  port 0 MIPS opcode (0x28 SB, 0x29 SH, else word).
- endereco0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse, port 0.
- rdata0  out  DATA_W  port 0 read data, valid when ack0=1.
- req1, we1, opcode1, endereco1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_endereco  out  ADDR_W  address to data memory.
- mem_write_data  out  DATA_W  write data to memory.
- mem_opcode  out  6  opcode forwarded to memory.
- sinal_mem_write  out  1  memory write strobe.
- sinal_mem_read  out  1  memory read strobe.
- mem_read_data  in  DATA_W  read data from memory.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, last_grant = 1 (so port 0 wins first).
- The reset check dominates every state; reset mid-access abandons the access silently, with no ack.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick a winner: if only one port requests, it wins; if both request, the port that is not last_grant wins.
  - Register the winner's we/opcode/addr/wdata into the mem_* outputs.
  - Set the strobe: sinal_mem_write = we, sinal_mem_read = ~we.
  - Update last_grant, load cnt = ACCESS_CYCLES-1, go to ACCESS.
- ACCESS:
  - Strobes and mem_* outputs stay stable.
  - While cnt != 0, decrement cnt.
  - When cnt == 0: capture mem_read_data into the winner's rdata (reads only; rdata of writes is unchanged), drop both strobes, go to RESP.
- RESP:
  - Pulse ack of the winner for exactly one cycle, then go to IDLE.
- Latency: req seen in IDLE at edge N gives strobes high from N+1 through N+ACCESS_CYCLES, and ack in cycle N+ACCESS_CYCLES+1. Minimum spacing between grants is ACCESS_CYCLES+2 cycles.
- Requester inputs are sampled only in IDLE; changes during ACCESS/RESP are ignored.
- A requester must deassert req in the cycle after its ack, otherwise it is treated as a new request.
- Requests are never lost; a losing requester is served on the next IDLE.
- mem_* data/address/opcode outputs hold their last value in IDLE; strobes are 0 in IDLE.
- The memory must never see both strobes high at once.
- rdata0/rdata1 hold their value until that port's next read completes.

Optional Feature:
- Macro: DATA_MEM_ARB_BOUNDS_EN.
- When defined:
  - Adds outputs err0 and err1 (1 bit each).
  - If the granted address is >= MEM_DEPTH, no strobe is asserted and the FSM goes IDLE -> RESP directly.
  - ack and err pulse together; rdata is forced to 0.
  - err is 0 on reset and whenever ack is 0.
- When undefined: no err ports; every address is forwarded unchecked.

Test Plan:
- Reset, then single read from port 0 with endereco0=5, memory returns 0xDEADBEEF, ACCESS_CYCLES=2 -> sinal_mem_read high 2 cycles, ack0 on the 4th cycle after req, rdata0=0xDEADBEEF.
- Port 1 SB write with opcode1=0x28, endereco1=3, wdata1=0x000000AB -> mem_opcode=0x28, sinal_mem_write high 2 cycles, ack1 pulses once, sinal_mem_read stays 0.
- req0 and req1 held continuously -> grants alternate 0,1,0,1; each ack is one cycle; there is no cycle with both strobes high.
- Reset asserted during ACCESS of a port 0 write -> next cycle strobes=0, busy=0, ack0 never pulses, next grant goes to port 0.
- With DATA_MEM_ARB_BOUNDS_EN and MEM_DEPTH=256, port 0 read at address 300 -> no strobe, ack0=err0=1 in the cycle after the grant, rdata0=0.
- Port 0 changes endereco0 during ACCESS -> mem_endereco stays at the originally sampled value until RESP.
